multicycle_control: RTL and testbench

//  Multi-cycle RV32 main control FSM: successor to the single-cycle decoder. Sequences

---
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with ready handshake, timeout and illegal traps.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit ENABLE_JAL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             reg_write,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_LOAD, S_WB_LOAD, S_MEM_STORE, S_BRANCH, S_JAL, S_TRAP
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // The cycle whose low mem_ready would make the wait count reach MEM_TIMEOUT traps.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               tmo_q, tmo_d;
    logic               retire, wait_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        tmo_d      = tmo_q;
        retire     = 1'b0;
        wait_tick  = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        reg_write  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL: begin
                        if (ENABLE_JAL) state_d = S_JAL;
                        else begin
                            illegal_d = 1'b1;
                            state_d   = S_TRAP;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEM_LOAD : S_MEM_STORE;
            end
            S_MEM_LOAD: begin
                mem_read = 1'b1;
                if (mem_ready) state_d = S_WB_LOAD;
                else           wait_tick = 1'b1;
            end
            S_WB_LOAD: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_STORE: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                case (funct3)
                    3'b000, 3'b001: begin
                        pc_write = funct3[0] ^ zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_source  = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // A late mem_ready on the limit cycle takes the normal path above, so no trap.
        if (wait_tick) begin
            if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                tmo_d   = 1'b1;
                state_d = S_TRAP;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
        if ((state_d != state_q) &&
            (state_d == S_FETCH || state_d == S_MEM_LOAD || state_d == S_MEM_STORE))
            wait_d = '0;

        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    assign illegal     = illegal_q;
    assign mem_timeout = tmo_q;
    assign instr_count = cnt_q;
    assign state       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized + directed check of multicycle_control against a per-instruction phase model;
// instance 0 uses defaults, instance 1 uses MEM_TIMEOUT=4, CNT_W=4, ENABLE_JAL=0.
module tb_multicycle_control;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_BAD = 6;

    // control vector: pc_write ir_write mem_read mem_write m2r[2] a[2] b[2] op[2] ps[2] reg_write
    localparam logic [14:0] C_ZERO  = '0;
    localparam logic [14:0] F_WAIT  = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] F_RDY   = {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] DECODE  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] EX_R    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] EX_I    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] WB_ALU  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [14:0] M_ADDR  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] M_LOAD  = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] WB_LOAD = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [14:0] M_STORE = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] BR_NT   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [14:0] BR_T    = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [14:0] JAL     = {1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic [6:0] opc [2];
    logic [2:0] f3  [2];
    logic       zr  [2];
    logic       rdy [2];
    logic [1:0] pcw, irw, mrd, mwr, rw, ill, tmo;
    logic [1:0][1:0] m2r, sa, sb, aop, ps;
    logic [1:0][3:0] st;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [14:0] ctl [2];

    multicycle_control u0 (
        .clk(clk), .reset(rst[0]), .opcode(opc[0]), .funct3(f3[0]), .zero(zr[0]),
        .mem_ready(rdy[0]), .pc_write(pcw[0]), .ir_write(irw[0]), .mem_read(mrd[0]),
        .mem_write(mwr[0]), .mem_to_reg(m2r[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]),
        .alu_op(aop[0]), .pc_source(ps[0]), .reg_write(rw[0]), .illegal(ill[0]),
        .mem_timeout(tmo[0]), .instr_count(cnt0), .state(st[0]));

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(4), .ENABLE_JAL(1'b0)) u1 (
        .clk(clk), .reset(rst[1]), .opcode(opc[1]), .funct3(f3[1]), .zero(zr[1]),
        .mem_ready(rdy[1]), .pc_write(pcw[1]), .ir_write(irw[1]), .mem_read(mrd[1]),
        .mem_write(mwr[1]), .mem_to_reg(m2r[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]),
        .alu_op(aop[1]), .pc_source(ps[1]), .reg_write(rw[1]), .illegal(ill[1]),
        .mem_timeout(tmo[1]), .instr_count(cnt1), .state(st[1]));

    for (genvar k = 0; k < 2; k++) begin : g_ctl
        assign ctl[k] = {pcw[k], irw[k], mrd[k], mwr[k], m2r[k], sa[k], sb[k], aop[k], ps[k], rw[k]};
    end

    // reference model state per instance
    int          lim    [2] = '{16, 4};
    bit          jal_en [2] = '{1'b1, 1'b0};
    logic [31:0] cnt_m  [2];
    bit          ill_m  [2];
    bit          tmo_m  [2];
    int n_pass = 0, n_fail = 0, n_tot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_obs(input int i);
        return (i == 0) ? cnt0 : {28'b0, cnt1};
    endfunction

    task automatic check_flags(input int i, input string tag);
        chk({tag, "_count"}, cnt_obs(i), cnt_m[i]);
        chk({tag, "_illegal"}, 32'(ill[i]), 32'(ill_m[i]));
        chk({tag, "_timeout"}, 32'(tmo[i]), 32'(tmo_m[i]));
    endtask

    // one clock: check outputs mid-cycle, then advance to just past the next edge
    task automatic cyc(input int i, input logic [14:0] e, input string tag);
        @(negedge clk);
        chk(tag, 32'(ctl[i]), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        #1;
        cnt_m[i] = '0; ill_m[i] = 1'b0; tmo_m[i] = 1'b0;
        chk("reset_outputs", 32'(ctl[i]), 32'(C_ZERO));
        check_flags(i, "reset");
        @(posedge clk);
        #1;
        rst[i] = 1'b0;
        cyc(i, C_ZERO, "idle");
    endtask

    // w cycles with mem_ready low, then one with it high; the w-th low cycle hitting the limit traps
    task automatic mem_phase(input int i, input logic [14:0] ew, input logic [14:0] er,
                             input int w, input string tag, output bit trapped);
        trapped = 1'b0;
        for (int k = 0; k < w; k++) begin
            rdy[i] = 1'b0;
            cyc(i, ew, tag);
            if (k + 1 == lim[i]) begin
                trapped  = 1'b1;
                tmo_m[i] = 1'b1;
                return;
            end
        end
        rdy[i] = 1'b1;
        cyc(i, er, tag);
    endtask

    task automatic run_instr(input int i, input int kind, input int fw, input int mw,
                             input logic z, input logic [2:0] fn3);
        bit tr;
        logic [6:0] op;
        case (kind)
            K_R:     op = 7'b0110011;
            K_I:     op = 7'b0010011;
            K_LD:    op = 7'b0000011;
            K_ST:    op = 7'b0100011;
            K_BR:    op = 7'b1100011;
            K_JAL:   op = 7'b1101111;
            default: op = 7'b1111111;
        endcase
        opc[i] = op;
        f3[i]  = fn3;
        mem_phase(i, F_WAIT, F_RDY, fw, "fetch", tr);
        if (tr) return;
        rdy[i] = 1'($urandom);
        zr[i]  = 1'($urandom);
        cyc(i, DECODE, "decode");
        if (kind == K_BAD || (kind == K_JAL && !jal_en[i])) begin
            ill_m[i] = 1'b1;
            return;
        end
        case (kind)
            K_R: begin cyc(i, EX_R, "exec_r"); cyc(i, WB_ALU, "wb_alu"); end
            K_I: begin cyc(i, EX_I, "exec_i"); cyc(i, WB_ALU, "wb_alu"); end
            K_LD: begin
                cyc(i, M_ADDR, "mem_addr_ld");
                mem_phase(i, M_LOAD, M_LOAD, mw, "mem_load", tr);
                if (tr) return;
                cyc(i, WB_LOAD, "wb_load");
            end
            K_ST: begin
                cyc(i, M_ADDR, "mem_addr_st");
                mem_phase(i, M_STORE, M_STORE, mw, "mem_store", tr);
                if (tr) return;
            end
            K_BR: begin
                zr[i] = z;
                if (fn3 > 3'd1) begin
                    cyc(i, BR_NT, "branch_bad_funct3");
                    ill_m[i] = 1'b1;
                    return;
                end
                // BEQ takes on zero, BNE on not-zero
                cyc(i, (((fn3 == 3'd0) && z) || ((fn3 == 3'd1) && !z)) ? BR_T : BR_NT, "branch");
            end
            default: cyc(i, JAL, "jal");
        endcase
        cnt_m[i] = cnt_m[i] + 1;
        if (i == 1) cnt_m[i] = cnt_m[i] & 32'hF;
        check_flags(i, "retire");
    endtask

    task automatic trap_check(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            rdy[i] = 1'($urandom);
            zr[i]  = 1'($urandom);
            opc[i] = 7'($urandom);
            cyc(i, C_ZERO, "trap_hold");
        end
        check_flags(i, "trap");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; opc[i] = '0; f3[i] = '0; zr[i] = 1'b0; rdy[i] = 1'b0;
            cnt_m[i] = '0; ill_m[i] = 1'b0; tmo_m[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        do_reset(1);
        do_reset(0);

        // directed: default instance
        run_instr(0, K_R, 0, 0, 1'b0, 3'b000);
        run_instr(0, K_LD, 0, 3, 1'b0, 3'b000);
        run_instr(0, K_BR, 0, 0, 1'b0, 3'b001);
        run_instr(0, K_BR, 1, 0, 1'b1, 3'b001);
        run_instr(0, K_BR, 0, 0, 1'b1, 3'b000);
        run_instr(0, K_BR, 2, 0, 1'b0, 3'b000);
        run_instr(0, K_JAL, 0, 0, 1'b0, 3'b000);
        run_instr(0, K_I, 1, 0, 1'b0, 3'b000);
        run_instr(0, K_ST, 0, 2, 1'b0, 3'b000);
        run_instr(0, K_R, 15, 0, 1'b0, 3'b000);
        run_instr(0, K_ST, 0, 15, 1'b0, 3'b000);

        // randomized legal traffic
        for (int n = 0; n < 40; n++)
            run_instr(0, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 3'($urandom_range(0, 1)));

        // asynchronous reset while reg_write is asserted
        opc[0] = 7'b0110011;
        rdy[0] = 1'b1;
        cyc(0, F_RDY, "mid_fetch");
        cyc(0, DECODE, "mid_decode");
        cyc(0, EX_R, "mid_exec");
        @(negedge clk);
        chk("mid_wb_alu", 32'(ctl[0]), 32'(WB_ALU));
        #1;
        do_reset(0);

        run_instr(0, K_BAD, 0, 0, 1'b0, 3'b000);
        trap_check(0, 10);
        do_reset(0);
        run_instr(0, K_BR, 0, 0, 1'b0, 3'b010);
        trap_check(0, 5);
        do_reset(0);

        // alternate instance: JAL disabled, 4-bit counter, timeout 4
        do_reset(1);
        run_instr(1, K_JAL, 0, 0, 1'b0, 3'b000);
        trap_check(1, 3);
        do_reset(1);
        run_instr(1, K_R, 3, 0, 1'b0, 3'b000);
        for (int n = 0; n < 15; n++)
            run_instr(1, $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 3'($urandom_range(0, 1)));
        chk("count_wrap", 32'(cnt1), 32'd0);
        run_instr(1, K_R, 4, 0, 1'b0, 3'b000);
        trap_check(1, 3);
        do_reset(1);
        run_instr(1, K_LD, 0, 4, 1'b0, 3'b000);
        trap_check(1, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
